// File: rtl/adda_capture_ctrl.sv
// rtl/adda_capture_ctrl.sv - triggered ADC capture sequencer with buffered valid/ready readout
module adda_capture_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] addata,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [7:0]        decim,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_READOUT = 2'd3;

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam int DEPTH = 1 << ADDR_W;

  logic [1:0]        state;
  logic [7:0]        dcnt;
  logic [DATA_W-1:0] s0;
  logic [DATA_W-1:0] s1;
  logic              s1_ok;
  logic [7:0]        decim_q;
  logic              mode_q;
  logic [DATA_W-1:0] level_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] raddr;
  logic              primed;
  logic              rd_valid_q;
  logic              triggered_q;
  logic              done_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  logic              run;
  logic              stb;
  logic              crossing;
  logic              fire;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              hs;
  logic              ram_en;

  // Strobe, trigger detection, buffer write and prefetch enables
  always_comb begin
    run      = (state == S_ARMED) || (state == S_CAPTURE);
    stb      = run && (dcnt == 8'd0);
    // s1 only holds a real sample after the first strobe of this run
    crossing = s1_ok && (s1 < level_q) && (s0 >= level_q);
    fire     = (state == S_ARMED) && stb && (mode_q || crossing);
    wr_en    = !abort && (fire || ((state == S_CAPTURE) && stb));
    wr_addr  = fire ? '0 : wr_ptr;
    hs       = rd_valid_q && rd_ready;
    // Load the RAM output register for the first sample and on every accepted sample
    ram_en   = !abort && (state == S_READOUT) && ((primed && !rd_valid_q) || hs);
  end

  // Sequencer state, sample pipeline, decimation counter and readout pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      dcnt        <= 8'd0;
      s0          <= '0;
      s1          <= '0;
      s1_ok       <= 1'b0;
      decim_q     <= 8'd0;
      mode_q      <= 1'b0;
      level_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      raddr       <= '0;
      primed      <= 1'b0;
      rd_valid_q  <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      s0     <= addata;
      done_q <= 1'b0;
      if (stb) s1 <= s0;
      if (run) dcnt <= stb ? decim_q : dcnt - 8'd1;
      if (abort) begin
        state       <= S_IDLE;
        triggered_q <= 1'b0;
        rd_valid_q  <= 1'b0;
        primed      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm) begin
              state   <= S_ARMED;
              dcnt    <= 8'd0;
              s1_ok   <= 1'b0;
              decim_q <= decim;
              mode_q  <= trig_mode;
              level_q <= trig_level;
            end
          end
          S_ARMED: begin
            if (stb) s1_ok <= 1'b1;
            if (fire) begin
              wr_ptr      <= PTR_ONE;
              triggered_q <= 1'b1;
              state       <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (stb) begin
              wr_ptr <= wr_ptr + PTR_ONE;
              if (wr_ptr == PTR_LAST) begin
                state  <= S_READOUT;
                rd_ptr <= '0;
                primed <= 1'b0;
              end
            end
          end
          default: begin
            // Address register is loaded first, then the RAM output; raddr then runs one ahead
            if (!primed) begin
              raddr  <= rd_ptr;
              primed <= 1'b1;
            end else if (!rd_valid_q) begin
              raddr      <= raddr + PTR_ONE;
              rd_valid_q <= 1'b1;
            end else if (rd_ready) begin
              raddr  <= raddr + PTR_ONE;
              rd_ptr <= rd_ptr + PTR_ONE;
              if (rd_ptr == PTR_LAST) begin
                state       <= S_IDLE;
                rd_valid_q  <= 1'b0;
                primed      <= 1'b0;
                triggered_q <= 1'b0;
                done_q      <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  // Record buffer with a registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= s0;
    if (ram_en) ram_q <= mem[raddr];
  end

  // Outputs are forced quiet whenever no sample is on offer
  always_comb begin
    rd_valid  = rd_valid_q;
    rd_data   = rd_valid_q ? ram_q : '0;
    rd_last   = rd_valid_q && (rd_ptr == PTR_LAST);
    busy      = (state != S_IDLE);
    triggered = triggered_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_adda_capture_ctrl.sv
// tb/tb_adda_capture_ctrl.sv - directed self-checking bench for adda_capture_ctrl
module tb_adda_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addata = 8'd0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       trig_mode = 1'b0;
  logic [7:0] trig_level = 8'd0;
  logic [7:0] decim = 8'd0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic       triggered;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit ramp = 1'b0;
  bit rand_ready = 1'b0;

  adda_capture_ctrl #(.ADDR_W(9), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .addata(addata), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_level(trig_level), .decim(decim),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ramp) addata = addata + 8'd1;
    if (done === 1'b1) done_cnt++;
    if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_arm(input logic mode, input logic [7:0] level, input logic [7:0] d);
    trig_mode  = mode;
    trig_level = level;
    decim      = d;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    while (rd_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_wait_valid"}, rd_valid, 1);
  endtask

  task automatic drain(input string tag, input logic [7:0] first, input logic [7:0] step,
                       input int n, input int arm_at, output int got);
    int bad_data, bad_last, bad_stall, guard;
    logic [7:0] expv, pdata;
    bit pstall, poked, el;
    bad_data = 0; bad_last = 0; bad_stall = 0; guard = 0;
    expv = first; pdata = 8'd0; pstall = 1'b0; poked = 1'b0;
    got = 0;
    while (got < n && guard < 20000) begin
      if (pstall && (rd_valid !== 1'b1 || rd_data !== pdata)) bad_stall++;
      el = (rd_valid === 1'b1) && (got == 511);
      if (rd_last !== el) bad_last++;
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
        if (rd_data !== expv) bad_data++;
        expv = expv + step;
        got++;
      end
      pstall = (rd_valid === 1'b1) && (rd_ready !== 1'b1);
      pdata = rd_data;
      if (!poked && arm_at > 0 && got == arm_at) begin
        arm = 1'b1;
        poked = 1'b1;
      end
      tick();
      arm = 1'b0;
      guard++;
    end
    chk({tag, "_bad_data"}, bad_data, 0);
    chk({tag, "_bad_last"}, bad_last, 0);
    chk({tag, "_bad_stall"}, bad_stall, 0);
  endtask

  initial begin
    int t0, got, trig_seen;
    logic [7:0] a;

    // Reset values
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    tick();
    chk("rst_triggered", triggered, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);

    // Run 1: immediate trigger, ramp, full-speed readout, arm during readout ignored
    ramp = 1'b1;
    rd_ready = 1'b1;
    done_cnt = 0;
    t0 = cyc;
    a = addata;
    do_arm(1'b1, 8'd0, 8'd0);
    chk("r1_busy_t1", busy, 1);
    chk("r1_trig_t1", triggered, 0);
    tick();
    chk("r1_trig_t2", triggered, 1);
    wait_valid("r1", 1000);
    chk("r1_latency", cyc - t0, 515);
    drain("r1", a, 8'd1, 512, 200, got);
    chk("r1_count", got, 512);
    chk("r1_done", done, 1);
    chk("r1_busy_end", busy, 0);
    tick();
    chk("r1_done_clear", done, 0);
    chk("r1_done_cnt", done_cnt, 1);
    chk("r1_trig_clear", triggered, 0);

    // Run 2: rising trigger with latched settings and random backpressure
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ramp = 1'b0;
    done_cnt = 0;
    addata = 8'h90;
    do_arm(1'b0, 8'h80, 8'd0);
    trig_mode = 1'b1;
    trig_level = 8'h00;
    decim = 8'd5;
    trig_seen = 0;
    repeat (5) begin
      tick();
      if (triggered === 1'b1) trig_seen++;
    end
    addata = 8'h10;
    repeat (3) begin
      tick();
      if (triggered === 1'b1) trig_seen++;
    end
    chk("r2_no_early_trig", trig_seen, 0);
    addata = 8'h85;
    ramp = 1'b1;
    tick();
    chk("r2_trig_c1", triggered, 0);
    tick();
    chk("r2_trig_c2", triggered, 1);
    wait_valid("r2", 1000);
    rand_ready = 1'b1;
    drain("r2", 8'h85, 8'd1, 512, 0, got);
    rand_ready = 1'b0;
    rd_ready = 1'b1;
    chk("r2_count", got, 512);
    chk("r2_busy_end", busy, 0);
    tick();
    chk("r2_done_cnt", done_cnt, 1);

    // Run 4: aborts in capture, together with arm, and in readout
    done_cnt = 0;
    do_arm(1'b1, 8'd0, 8'd0);
    repeat (100) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("r4_cap_busy", busy, 0);
    chk("r4_cap_trig", triggered, 0);
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    chk("r4_arm_abort_busy", busy, 0);
    a = addata;
    do_arm(1'b1, 8'd0, 8'd0);
    wait_valid("r4", 1000);
    drain("r4", a, 8'd1, 100, 0, got);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("r4_rd_valid", rd_valid, 0);
    chk("r4_rd_busy", busy, 0);
    repeat (5) tick();
    chk("r4_no_done", done_cnt, 0);

    // Run 3: decimation by 4 after the aborts
    done_cnt = 0;
    t0 = cyc;
    a = addata;
    do_arm(1'b1, 8'd0, 8'd3);
    wait_valid("r3", 3000);
    chk("r3_latency", cyc - t0, 2048);
    drain("r3", a, 8'd4, 512, 0, got);
    chk("r3_count", got, 512);
    chk("r3_done", done, 1);
    tick();
    chk("r3_done_cnt", done_cnt, 1);

    // Run 5: asynchronous reset between edges during readout
    a = addata;
    do_arm(1'b1, 8'd0, 8'd0);
    wait_valid("r5", 1000);
    drain("r5", a, 8'd1, 50, 0, got);
    #2 rst = 1'b1;
    #1;
    chk("r5_rd_valid", rd_valid, 0);
    chk("r5_busy", busy, 0);
    chk("r5_rd_data", rd_data, 0);
    chk("r5_triggered", triggered, 0);
    #1 rst = 1'b0;
    tick();
    chk("r5_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adda_capture_ctrl.md
# adda_capture_ctrl

Triggered capture sequencer for the 8-bit ADC path of the AD/DA board. It samples `addata` at a programmable decimation rate and waits in an armed state for a level-crossing trigger (or triggers immediately). It then records a fixed-length record into an internal buffer and streams the record out over a valid/ready interface to the UART/display consumer. It runs on the same clock that drives `adclk`/`daclk` and replaces free-running `addata` registering wherever a stable snapshot is needed.

## Interface
- `ADDR_W`, default 9: buffer address width; record length is 2^ADDR_W samples (512).
- `DATA_W`, default 8: sample width; matches the ADC bus.
- `clk`  in  1  system clock; the same clock forwarded to the ADC as `adclk`.
- `rst`  in  1  asynchronous, active-high reset.
- `addata`  in  DATA_W  raw ADC data, sampled on the rising edge of `clk`.
- `arm`  in  1  single-cycle start request; honoured only in IDLE.
- `abort`  in  1  returns the block to IDLE from any state.
- `trig_mode`  in  1  0 = rising-level trigger, 1 = immediate trigger.
- `trig_level`  in  DATA_W  trigger threshold, unsigned.
- `decim`  in  8  sample every `decim`+1 clocks; 0 means every clock.
- `rd_valid`  out  1  readout sample valid.
- `rd_ready`  in  1  consumer accepts the sample.
- `rd_data`  out  DATA_W  readout sample.
- `rd_last`  out  1  high with the final sample of the record.
- `busy`  out  1  high in every state except IDLE.
- `triggered`  out  1  high from the trigger event until return to IDLE.
- `done`  out  1  one-cycle pulse when the record has been fully read out.

## Operation
- Input pipeline: `s0` <= `addata` on every clock; `s1` <= `s0` only on the sample strobe `stb`.
- Decimation counter `dcnt` (8 bit): cleared on entry to ARMED. `stb` = (`dcnt` == 0). When `stb` is high, `dcnt` <= `decim`; otherwise `dcnt` decrements. The counter runs only in ARMED and CAPTURE.
- `decim`, `trig_mode` and `trig_level` are latched on `arm` acceptance. Later changes to these inputs do not affect the run in progress.
- States:
  - IDLE: outputs quiet. `arm` -> ARMED.
  - ARMED: on `stb`, trigger when `trig_mode` = 1, or when (`s1` < level) and (`s0` >= level). The first strobe after arming never triggers in mode 0, because `s1` is not yet valid. On trigger, `s0` is written to buffer address 0, `wr_ptr` <= 1, `triggered` is set, and the state -> CAPTURE.
  - CAPTURE: on each `stb`, write `s0` at `wr_ptr` and increment `wr_ptr`. After the write at address 2^ADDR_W-1, go -> READOUT with `rd_ptr` = 0.
  - READOUT: the buffer has a registered read port (one-cycle latency). The block prefetches the next sample so that `rd_valid` can stay high on back-to-back handshakes. A handshake (`rd_valid` & `rd_ready`) advances `rd_ptr`. `rd_last` = `rd_valid` & (`rd_ptr` == 2^ADDR_W-1). On the last handshake, go -> IDLE and pulse `done`.
- `rd_data`/`rd_last` hold stable while `rd_valid` is high and `rd_ready` is low.
- `abort` has priority over every other event in the same cycle:
  - next state is IDLE;
  - `triggered` and `rd_valid` clear;
  - `done` does not pulse;
  - buffer contents are left undefined.
- `arm` and `abort` asserted in the same cycle: `abort` wins and the block stays IDLE.
- Pointer arithmetic is modulo 2^ADDR_W. A full record is exactly 2^ADDR_W writes and never overwrites itself.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `triggered`, `done`, `rd_valid`, `rd_last` all 0;
  - `rd_data` 0; `dcnt` 0; `wr_ptr` 0; `rd_ptr` 0; `s0` 0; `s1` 0.
- `arm` at cycle T: `busy` = 1 from T+1. The first `stb` occurs at T+1.
- Trigger latency: an `addata` value present before edge E is in `s0` after E. A trigger at the next strobe is visible as `triggered` = 1 one cycle later.
- Capture duration with `decim` = D: 2^ADDR_W × (D+1) clocks, counted from the trigger strobe.
- First `rd_valid`: 2 cycles after entering READOUT (address register plus RAM read).
- Throughput: one sample per clock while `rd_ready` is held high.
- `done` is asserted in the cycle after the last handshake, coincident with `busy` = 0.
- Reset mid-capture or mid-readout: all outputs return to their reset values immediately, without waiting for a clock edge.

## Test plan
- Immediate mode, `decim`=0, `addata` = counter 0..255 repeating, `rd_ready`=1 -> 512 samples read out; consecutive readout values differ by 1 mod 256; `rd_last` high on the 512th sample only; one `done` pulse.
- Rising trigger, level 0x80, `addata` = sine from the DA ROM looped back -> first read sample >= 0x80, and the sample preceding the trigger was < 0x80. `triggered` rises exactly once.
- `decim`=3 with a ramp input -> consecutive stored samples differ by 4; capture lasts 2048 clocks.
- Random `rd_ready` backpressure (50%) -> `rd_data` stable while stalled; no sample lost or duplicated; 512 handshakes in total.
- `abort` mid-CAPTURE and mid-READOUT -> `busy`=0 next cycle; no `done`; a fresh `arm` then completes a normal run.
- Async `rst` pulse between clock edges during READOUT -> `rd_valid`=0 and `busy`=0 immediately; `arm` while not IDLE is ignored (no restart, record unchanged).
